segre_mem_responder: RTL and testbench
======================================

# segre_mem_responder

Line-granular memory responder that sits on the far side of the core's memory port and answers the requests `segre_core` issues. It receives address, read/write strobes, data type and a write cache line, models a fixed access latency, and then returns a one-cycle ready pulse with the read line. It is the behavioural main memory used in core-level simulation, and is written to be synthesizable as an on-chip RAM wrapper.

## Interface
- `CACHE_LINE_SIZE_BYTES`, default 16 (from `segre_pkg`): bytes per line.
- `ADDR_SIZE`, default 32: request address width.
- `MEM_DEPTH_LINES`, default 1024: number of lines stored. Power of two, ≥ 2.
- `LATENCY`, default 4: cycles from request sample to ready pulse. Must be ≥ 1.

Ports:
- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rsn_i`  in  1  reset, synchronous, active-high.
- `addr_i`  in  ADDR_SIZE  request byte address.
- `mem_rd_i`  in  1  read request level.
- `mem_wr_i`  in  1  write request level.
- `mem_data_type_i`  in  memop_data_type_e  access type. Latched with the request; does not affect data movement.
- `mem_wr_data_i`  in  [CACHE_LINE_SIZE_BYTES-1:0][7:0]  write line.
- `mem_rd_data_o`  out  [CACHE_LINE_SIZE_BYTES-1:0][7:0]  read line, registered.
- `mem_ready_o`  out  1  response pulse.
- `busy_o`  out  1  high in any state other than IDLE.
- `err_o`  out  1  error flag, valid only while `mem_ready_o` is high.

## Operation
- **Offset bits:** OFF = log2(CACHE_LINE_SIZE_BYTES).
- **Line index:** `addr_i[ADDR_SIZE-1:OFF]`. Offset bits are ignored; every access is a full line.
- **Range check:** an index ≥ MEM_DEPTH_LINES is out of range.
- **Storage:** array of MEM_DEPTH_LINES lines. The array is not reset; simulation contents are X until written.

State machine:
- **IDLE**
  - If `mem_rd_i | mem_wr_i`, latch index, range flag, op, write line and data type.
  - Go to BUSY if LATENCY > 1, otherwise go to RESP.
- **BUSY**
  - Load the down-counter with LATENCY-1 on entry; decrement each cycle.
  - Go to RESP when the counter reaches 1.
  - Inputs are ignored.
- **RESP**
  - `mem_ready_o` = 1 for exactly this cycle.
  - Go to IDLE unconditionally.
  - Requests seen during RESP are ignored.

Commit, on the clock edge that enters RESP:
- **In-range write:** write the latched line into the array. `mem_rd_data_o` keeps its previous value.
- **In-range read:** `mem_rd_data_o` ← array[index].
- **Out-of-range read:** `mem_rd_data_o` ← 0 and `err_o` = 1.
- **Out-of-range write:** array unchanged, `err_o` = 1.

Other rules:
- **Read and write asserted together in IDLE:** perform a read, do not write, `err_o` = 1.
- **Data hold:** `mem_rd_data_o` holds its value until the next read commit.
- **Requester contract:** hold address, strobes and data stable from assertion until ready. A request still asserted in the cycle after RESP is treated as a new request.

## Timing
- **Reset values:** `mem_ready_o`=0, `busy_o`=0, `err_o`=0, `mem_rd_data_o`=0, state IDLE, counter 0.
- **Reset mid-transaction:** abort. No array write and no ready pulse. Memory contents are untouched.
- **Latency:** request sampled in IDLE at cycle t, ready at cycle t+LATENCY.
- **Busy window:** `busy_o` is high for cycles t+1 … t+LATENCY.
- **Throughput:** one transaction per LATENCY+1 cycles, since the IDLE cycle after RESP is mandatory.
- **Counter width:** $clog2(LATENCY+1). It never wraps.
- **Ordering:** a read issued after a write to the same line returns the new data. Transactions are strictly serialized.
- **No combinational paths** from inputs to outputs.

## Test plan
- **Write then read (LATENCY=4):**
  - Write to 0x40 with byte i = i (0x00..0x0F), request sampled at cycle 0 → `mem_ready_o` high only at cycle 4, `err_o`=0, `busy_o` high cycles 1–4.
  - Read 0x40 → ready 4 cycles after its sample, `mem_rd_data_o` = 0x0F…0x00.
- **Offset ignored:** after the write above, read 0x4C → returns the line at 0x40. A write to 0x41 overwrites line 0x40.
- **Out of range (MEM_DEPTH_LINES=1024):**
  - Read 0x4000 → data all zeros, `err_o`=1 with ready.
  - Write 0x4000 → `err_o`=1, and a later read of 0x0 is unchanged.
- **Read and write together:** `mem_rd_i`=`mem_wr_i`=1 at 0x40 with all-0xFF data → read returns the old line, `err_o`=1, and a following read still returns the old line.
- **Reset mid-write:** `rsn_i` high at cycle 2 of a write to 0x80 → no ready pulse, all outputs 0 the next cycle, and a later read of 0x80 returns the pre-write contents.
- **Held request (LATENCY=4, LATENCY=1):**
  - LATENCY=4: request held continuously from cycle 0 → ready at cycles 4, 9, 14. Nothing is accepted during RESP.
  - LATENCY=1: ready at cycles 1, 3, 5.

Source files
------------

// File: rtl/segre_mem_responder.sv
// Line-granular behavioural main memory for segre_core: fixed-latency responder
// that commits a full cache line per request and answers with a one-cycle ready pulse.
package segre_pkg;
  localparam int CACHE_LINE_SIZE_BYTES = 16;

  typedef enum logic [2:0] {
    MEMOP_BYTE,
    MEMOP_HALF,
    MEMOP_WORD,
    MEMOP_UBYTE,
    MEMOP_UHALF
  } memop_data_type_e;
endpackage

module segre_mem_responder
  import segre_pkg::*;
#(
  parameter int CACHE_LINE_SIZE_BYTES = segre_pkg::CACHE_LINE_SIZE_BYTES,
  parameter int ADDR_SIZE             = 32,
  parameter int MEM_DEPTH_LINES       = 1024,
  parameter int LATENCY               = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rsn_i,
  input  logic [ADDR_SIZE-1:0]                 addr_i,
  input  logic                                 mem_rd_i,
  input  logic                                 mem_wr_i,
  input  memop_data_type_e                     mem_data_type_i,
  input  logic [CACHE_LINE_SIZE_BYTES-1:0][7:0] mem_wr_data_i,
  output logic [CACHE_LINE_SIZE_BYTES-1:0][7:0] mem_rd_data_o,
  output logic                                 mem_ready_o,
  output logic                                 busy_o,
  output logic                                 err_o
);
  localparam int OFF    = $clog2(CACHE_LINE_SIZE_BYTES);
  localparam int IDX_W  = ADDR_SIZE - OFF;
  localparam int MEM_AW = $clog2(MEM_DEPTH_LINES);
  localparam int CNT_W  = $clog2(LATENCY + 1);
  localparam bit DIRECT = (LATENCY == 1);

  // Handshake: a request is a level on mem_rd_i/mem_wr_i seen while idle; the
  // requester holds address, strobes and data until mem_ready_o pulses for one
  // cycle. Inputs are not looked at again until the cycle after that pulse.
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;

  state_e                                state_q;
  logic [CNT_W-1:0]                      cnt_q;
  logic [MEM_AW-1:0]                     idx_q;
  logic                                  oor_q;
  logic                                  rd_q;
  logic                                  wr_q;
  logic [CACHE_LINE_SIZE_BYTES-1:0][7:0] wdata_q;
  memop_data_type_e                      type_q;

  logic [CACHE_LINE_SIZE_BYTES-1:0][7:0] mem [MEM_DEPTH_LINES];

  logic [IDX_W-1:0]                      req_idx_full;
  logic [MEM_AW-1:0]                     req_idx;
  logic                                  req_oor;
  logic                                  req;
  logic                                  enter_resp;
  logic [MEM_AW-1:0]                     c_idx;
  logic                                  c_oor;
  logic                                  c_rd;
  logic                                  c_wr;
  logic [CACHE_LINE_SIZE_BYTES-1:0][7:0] c_wdata;
  logic                                  c_do_wr;
  logic                                  c_err;
  logic                                  unused_bits;

  assign req_idx_full = addr_i[ADDR_SIZE-1:OFF];
  assign req_idx      = req_idx_full[MEM_AW-1:0];
  assign req_oor      = (req_idx_full >> MEM_AW) != '0;
  assign req          = mem_rd_i | mem_wr_i;
  assign unused_bits  = ^{addr_i[OFF-1:0], type_q};

  // With LATENCY==1 the commit happens straight from IDLE, so the commit
  // operands come from the live inputs there and from the latches otherwise.
  always_comb begin
    enter_resp = 1'b0;
    c_idx      = idx_q;
    c_oor      = oor_q;
    c_rd       = rd_q;
    c_wr       = wr_q;
    c_wdata    = wdata_q;
    if (state_q == S_IDLE) begin
      enter_resp = DIRECT && req;
      c_idx      = req_idx;
      c_oor      = req_oor;
      c_rd       = mem_rd_i;
      c_wr       = mem_wr_i;
      c_wdata    = mem_wr_data_i;
    end else if (state_q == S_BUSY) begin
      enter_resp = (cnt_q == CNT_W'(1));
    end
    c_do_wr = c_wr & ~c_rd & ~c_oor;
    c_err   = c_oor | (c_rd & c_wr);
  end

  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      oor_q         <= 1'b0;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      type_q        <= MEMOP_BYTE;
      mem_ready_o   <= 1'b0;
      busy_o        <= 1'b0;
      err_o         <= 1'b0;
      mem_rd_data_o <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          mem_ready_o <= 1'b0;
          err_o       <= 1'b0;
          if (req) begin
            idx_q   <= req_idx;
            oor_q   <= req_oor;
            rd_q    <= mem_rd_i;
            wr_q    <= mem_wr_i;
            wdata_q <= mem_wr_data_i;
            type_q  <= mem_data_type_i;
            busy_o  <= 1'b1;
            if (DIRECT) begin
              state_q <= S_RESP;
            end else begin
              state_q <= S_BUSY;
              cnt_q   <= CNT_W'(LATENCY - 1);
            end
          end
        end
        S_BUSY: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= S_RESP;
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          mem_ready_o <= 1'b0;
          err_o       <= 1'b0;
          busy_o      <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase

      if (enter_resp) begin
        mem_ready_o <= 1'b1;
        err_o       <= c_err;
        if (c_rd) mem_rd_data_o <= c_oor ? '0 : mem[c_idx];
      end
    end
  end

  // Storage is deliberately not reset so it maps onto a plain RAM macro.
  always_ff @(posedge clk_i) begin
    if (!rsn_i && enter_resp && c_do_wr) mem[c_idx] <= c_wdata;
  end
endmodule

// File: tb/tb_segre_mem_responder.sv
// Bench for segre_mem_responder: vector table, random write/read pairs,
// reset abort and back-to-back held requests at LATENCY 4 and 1.
module tb_segre_mem_responder;
  import segre_pkg::*;

  localparam int LAT = 4;

  logic                 clk = 1'b0;
  logic                 rsn = 1'b1;
  logic [31:0]          addr = '0;
  logic                 mem_rd = 1'b0;
  logic                 mem_wr = 1'b0;
  memop_data_type_e     dtype = MEMOP_WORD;
  logic [15:0][7:0]     wdata = '0;
  logic [15:0][7:0]     rdata;
  logic                 ready;
  logic                 busy;
  logic                 err;

  logic [31:0]          addr1 = '0;
  logic                 rd1 = 1'b0;
  logic                 wr1 = 1'b0;
  logic [15:0][7:0]     wdata1 = '0;
  logic [15:0][7:0]     rdata1;
  logic                 ready1;
  logic                 busy1;
  logic                 err1;

  int checks = 0;
  int failures = 0;

  logic [128:0] exp_q[$];

  segre_mem_responder #(.LATENCY(LAT)) dut (
    .clk_i(clk), .rsn_i(rsn), .addr_i(addr), .mem_rd_i(mem_rd), .mem_wr_i(mem_wr),
    .mem_data_type_i(dtype), .mem_wr_data_i(wdata), .mem_rd_data_o(rdata),
    .mem_ready_o(ready), .busy_o(busy), .err_o(err)
  );

  segre_mem_responder #(.LATENCY(1)) dut1 (
    .clk_i(clk), .rsn_i(rsn), .addr_i(addr1), .mem_rd_i(rd1), .mem_wr_i(wr1),
    .mem_data_type_i(dtype), .mem_wr_data_i(wdata1), .mem_rd_data_o(rdata1),
    .mem_ready_o(ready1), .busy_o(busy1), .err_o(err1)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [128:0] act,
                       input logic [128:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h want=%h", name, idx, act, exp);
    end
  endtask

  // driver: one full transaction, cycle-by-cycle ready/busy checks, scoreboard pop on ready
  task automatic run_txn(input int idx, input logic [31:0] a, input logic rd, input logic wr,
                         input logic [127:0] wd, input logic exp_err, input logic [127:0] exp_data);
    logic got;
    logic [128:0] e;
    got = 1'b0;
    @(negedge clk);
    addr = a; mem_rd = rd; mem_wr = wr; wdata = wd;
    exp_q.push_back({exp_err, exp_data});
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge clk); #1;
      check("ready", idx * 10 + k, {128'd0, ready}, {128'd0, (k == LAT)});
      check("busy", idx * 10 + k, {128'd0, busy}, {128'd0, (k <= LAT)});
      if (ready && !got && exp_q.size() > 0) begin
        got = 1'b1;
        e = exp_q.pop_front();
        check("resp", idx, {err, rdata}, e);
      end
      if (k == LAT) begin
        mem_rd = 1'b0; mem_wr = 1'b0;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL timeout[%0d] got=no_ready want=ready", idx);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  typedef struct {
    logic [31:0]  addr;
    logic         rd;
    logic         wr;
    logic [127:0] wd;
    logic         exp_err;
    logic [127:0] exp_data;
  } vec_t;

  localparam logic [127:0] P_INC = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] P_Z0  = 128'h11112222333344445555666677778888;
  localparam logic [127:0] P_B   = 128'hDEADBEEFCAFEF00D0123456789ABCDEF;
  localparam logic [127:0] P_C   = 128'h5A5A5A5AA5A5A5A5C3C3C3C33C3C3C3C;
  localparam logic [127:0] P_D   = 128'h99999999888888887777777766666666;
  localparam logic [127:0] P_FF  = {128{1'b1}};

  vec_t vecs[13];

  initial begin
    logic [127:0] last;
    logic [127:0] rnd;
    logic [31:0]  raddr;

    vecs[0]  = '{32'h0000_0000, 1'b0, 1'b1, P_Z0,  1'b0, 128'd0};
    vecs[1]  = '{32'h0000_0040, 1'b0, 1'b1, P_INC, 1'b0, 128'd0};
    vecs[2]  = '{32'h0000_0040, 1'b1, 1'b0, P_FF,  1'b0, P_INC};
    vecs[3]  = '{32'h0000_004C, 1'b1, 1'b0, '0,    1'b0, P_INC};
    vecs[4]  = '{32'h0000_4000, 1'b1, 1'b0, '0,    1'b1, 128'd0};
    vecs[5]  = '{32'h0000_4000, 1'b0, 1'b1, P_FF,  1'b1, 128'd0};
    vecs[6]  = '{32'h0000_0000, 1'b1, 1'b0, '0,    1'b0, P_Z0};
    vecs[7]  = '{32'h0000_0040, 1'b1, 1'b1, P_FF,  1'b1, P_INC};
    vecs[8]  = '{32'h0000_0040, 1'b1, 1'b0, '0,    1'b0, P_INC};
    vecs[9]  = '{32'h0000_0041, 1'b0, 1'b1, P_B,   1'b0, P_INC};
    vecs[10] = '{32'h0000_0040, 1'b1, 1'b0, '0,    1'b0, P_B};
    vecs[11] = '{32'h0000_0080, 1'b0, 1'b1, P_C,   1'b0, P_B};
    vecs[12] = '{32'h0000_0080, 1'b1, 1'b0, '0,    1'b0, P_C};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rsn = 1'b0;
    check("reset_out", 0, {ready, busy, err, rdata}, '0);
    check("reset_out1", 0, {ready1, busy1, err1, rdata1}, '0);

    foreach (vecs[i])
      run_txn(i, vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wd, vecs[i].exp_err, vecs[i].exp_data);
    last = P_C;

    for (int i = 0; i < 4; i++) begin
      raddr = 32'($urandom_range(16, 1023)) << 4;
      rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_txn(20 + 2 * i, raddr, 1'b0, 1'b1, rnd, 1'b0, last);
      run_txn(21 + 2 * i, raddr | 32'($urandom_range(0, 15)), 1'b1, 1'b0, '0, 1'b0, rnd);
      last = rnd;
    end

    // reset lands while a write to 0x80 is still in flight
    @(negedge clk);
    addr = 32'h80; mem_wr = 1'b1; wdata = P_D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_ready", 1, {128'd0, ready}, '0);
    @(negedge clk);
    rsn = 1'b1;
    @(posedge clk); #1;
    check("abort_out", 2, {ready, busy, err, rdata}, '0);
    @(negedge clk);
    rsn = 1'b0; mem_wr = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      @(posedge clk); #1;
      check("abort_noresp", k, {128'd0, ready}, '0);
    end
    run_txn(40, 32'h80, 1'b1, 1'b0, '0, 1'b0, P_C);

    // held request, LATENCY=4: pulses at 4, 9, 14
    @(negedge clk);
    addr = 32'h40; mem_rd = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      check("held4", k, {128'd0, ready}, {128'd0, (k == 4 || k == 9 || k == 14)});
    end
    @(negedge clk);
    mem_rd = 1'b0;

    // held request, LATENCY=1: pulses at 1, 3, 5
    @(negedge clk);
    addr1 = 32'h40; wr1 = 1'b1; wdata1 = P_INC;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      check("held1", k, {128'd0, ready1}, {128'd0, (k == 1 || k == 3 || k == 5)});
    end
    @(negedge clk);
    wr1 = 1'b0;
    @(negedge clk);
    addr1 = 32'h4C; rd1 = 1'b1;
    @(posedge clk); #1;
    check("lat1_read", 0, {err1, rdata1}, {1'b0, P_INC});
    @(negedge clk);
    rd1 = 1'b0;

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
